// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the multiply/divide unit: divider FSM encoding,
//   default datapath width, iteration count, sign-bookkeeping record, and
//   the well-known special-case results (divide by zero, signed overflow)
//   so that other blocks and benches refer to the same values.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Default operand/result width (MIPS GPR width).
    localparam int MDU_WIDTH = 32;

    // One restoring step per quotient bit.
    localparam int DIV_ITERS = MDU_WIDTH;

    // Divider FSM encoding.
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

    // Divide-by-zero outcomes. The remainder is always the dividend itself.
    localparam logic [MDU_WIDTH-1:0] DIV0_LO_UNSIGNED   = 32'hFFFF_FFFF;
    localparam logic [MDU_WIDTH-1:0] DIV0_LO_SIGNED_NEG = 32'h0000_0001;
    localparam logic [MDU_WIDTH-1:0] DIV0_LO_SIGNED_POS = 32'hFFFF_FFFF;

    // Signed overflow: most-negative / -1.
    localparam logic [MDU_WIDTH-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [MDU_WIDTH-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [MDU_WIDTH-1:0] OVF_LO       = 32'h8000_0000;
    localparam logic [MDU_WIDTH-1:0] OVF_HI       = 32'h0000_0000;

    // Sign bookkeeping captured when a division starts.
    typedef struct packed {
        logic is_signed;   // DIV (1) or DIVU (0)
        logic q_neg;       // quotient must be negated at fix-up
        logic r_neg;       // remainder must be negated at fix-up
    } div_sign_t;

    // An operand is treated as negative only in signed mode.
    function automatic logic operand_negative(input logic is_signed,
                                              input logic msb);
        return is_signed & msb;
    endfunction

endpackage

// File: rtl/div_sign_cond.sv
// ---------------------------------------------------------------------------
// div_sign_cond
//   Combinational conditional two's-complement negate. Used both to take
//   operand magnitudes (negate when the operand is negative) and to apply
//   the result signs after the unsigned core has finished.
//   Negation wraps modulo 2^WIDTH, so the most-negative value maps to
//   itself, which read as unsigned is exactly its magnitude.
//
//   Ports:
//     value_i   in  WIDTH  value to condition
//     negate_i  in  1      1 = output -value_i, 0 = pass through
//     result_o  out WIDTH  conditioned value
// ---------------------------------------------------------------------------
module div_sign_cond
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        if (negate_i) begin
            result_o = (~value_i) + WIDTH'(1);
        end else begin
            result_o = value_i;
        end
    end

endmodule

// File: rtl/seq_hilo_divider.sv
// ---------------------------------------------------------------------------
// seq_hilo_divider
//   Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. Produces the
//   HI (remainder) / LO (quotient) write data with a fixed latency: done
//   pulses 33 cycles after the edge that samples start. The HI/LO
//   architectural registers live outside; the consumer ORs done into their
//   write enable.
//
//   The core always divides magnitudes; signs are recorded at start and
//   applied in a single fix-up cycle at the end.
//
//   Ports:
//     clk        in  1      rising-edge clock
//     rst        in  1      asynchronous active-low reset
//     start      in  1      begin a division (honoured only when idle)
//     is_signed  in  1      1 = DIV, 0 = DIVU (sampled with start)
//     dividend   in  WIDTH  rs operand (sampled with start)
//     divisor    in  WIDTH  rt operand (sampled with start)
//     flush      in  1      synchronous abort, returns to idle, no done
//     busy       out 1      division in progress
//     done       out 1      one-cycle pulse, hi/lo valid
//     hi         out WIDTH  remainder, held until the next completion
//     lo         out WIDTH  quotient, held until the next completion
// ---------------------------------------------------------------------------
module seq_hilo_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // -----------------------------------------------------------------
    // State
    // -----------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
    logic [WIDTH-1:0] quo_q,   quo_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor magnitude
    div_sign_t        sign_q,  sign_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             done_q,  done_d;

    // -----------------------------------------------------------------
    // Operand conditioning: index 0 = dividend, 1 = divisor
    // -----------------------------------------------------------------
    logic [WIDTH-1:0] opnd_raw [2];
    logic [WIDTH-1:0] opnd_mag [2];
    logic             opnd_neg [2];

    assign opnd_raw[0] = dividend;
    assign opnd_raw[1] = divisor;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            assign opnd_neg[gi] = operand_negative(is_signed, opnd_raw[gi][WIDTH-1]);

            div_sign_cond #(
                .WIDTH(WIDTH)
            ) u_abs (
                .value_i (opnd_raw[gi]),
                .negate_i(opnd_neg[gi]),
                .result_o(opnd_mag[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------
    // Result fix-up
    // -----------------------------------------------------------------
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;
    logic             lo_negate;
    logic             hi_negate;

    // Unsigned operations never negate, even if a stale flag were set.
    assign lo_negate = sign_q.is_signed & sign_q.q_neg;
    assign hi_negate = sign_q.is_signed & sign_q.r_neg;

    div_sign_cond #(
        .WIDTH(WIDTH)
    ) u_fix_lo (
        .value_i (quo_q),
        .negate_i(lo_negate),
        .result_o(lo_fix)
    );

    div_sign_cond #(
        .WIDTH(WIDTH)
    ) u_fix_hi (
        .value_i (rem_q),
        .negate_i(hi_negate),
        .result_o(hi_fix)
    );

    // -----------------------------------------------------------------
    // Restoring step
    //   shifted = {rem, next dividend bit}; the trial difference is one
    //   bit wider than the operands so its MSB is the borrow. Since the
    //   partial remainder stays below the divisor (or, for a zero divisor,
    //   holds at most WIDTH dividend bits) the shifted value never needs
    //   more than WIDTH+1 bits.
    // -----------------------------------------------------------------
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign trial_ok = ~trial[WIDTH];

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (flush) begin
            // Abort from any state; a coincident start is dropped and
            // hi/lo keep whatever the last completed division left.
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d          = DIV_CALC;
                        cnt_d            = CNT_W'(WIDTH);
                        rem_d            = '0;
                        quo_d            = opnd_mag[0];
                        dvs_d            = opnd_mag[1];
                        sign_d.is_signed = is_signed;
                        sign_d.q_neg     = opnd_neg[0] ^ opnd_neg[1];
                        sign_d.r_neg     = opnd_neg[0];
                    end
                end

                DIV_CALC: begin
                    if (trial_ok) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    // The step taken with the counter at 1 is the last one.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DIV_FIX;
                    end
                end

                DIV_FIX: begin
                    hi_d    = hi_fix;
                    lo_d    = lo_fix;
                    done_d  = 1'b1;
                    state_d = DIV_IDLE;
                end

                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sign_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign busy = (state_q != DIV_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_hilo_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_hilo_divider
//   Scoreboard bench: the driver pushes the reference result for every
//   division it launches; an independent monitor pops and compares on each
//   done pulse, including the completion cycle.
// ---------------------------------------------------------------------------
module tb_seq_hilo_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    seq_hilo_divider #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int unsigned  due;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           passes = 0;
    int           done_count = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: plain integer division with MIPS truncation; the
    // zero-divisor results follow the documented algorithmic outcome.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit s, output logic [W-1:0] q_o,
                                    output logic [W-1:0] r_o);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (!s) begin
            if (b == 0) begin
                q_o = 32'hFFFF_FFFF;
                r_o = a;
            end else begin
                q_o = a / b;
                r_o = a % b;
            end
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            if (sb == 0) begin
                q_o = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
                r_o = a;
            end else begin
                q   = sa / sb;   // truncates toward zero
                r   = sa % sb;   // takes the dividend's sign
                q_o = q[W-1:0];  // 2^31 wraps to 0x80000000 for overflow
                r_o = r[W-1:0];
            end
        end
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done at cycle %0d, required no pending division", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
                check({mon_e.name, "_busy_low_at_done"}, 64'(busy), 64'(0));
                last_lo = mon_e.lo;
                last_hi = mon_e.hi;
            end
        end
    end

    // Must be called at a negedge with the DUT idle; returns one negedge later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input string name, input bit expect_done);
        exp_t e;
        logic [W-1:0] q;
        logic [W-1:0] r;
        ref_div(a, b, s, q, r);
        e.lo   = q;
        e.hi   = r;
        e.due  = cyc + 34;   // sampling edge plus 33 cycles, seen at the following negedge
        e.name = name;
        if (expect_done) sb_q.push_back(e);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;   // must have no effect once sampled
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Launch, then wait (bounded) for done; leaves the bench at the done negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input string name, input bit chk_busy);
        int n;
        int busy_cnt;
        issue(a, b, s, name, 1'b1);
        n = 0;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL %s_timeout: no done within 100 cycles, required done at 33", name);
        end
        if (chk_busy) check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
    endtask

    logic [W-1:0] da [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, 32'hFFFF_FFF0,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0};
    logic [W-1:0] db [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5};
    bit           ds [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int dc0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit s;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Directed cases, back to back (next start sampled at E34)
        for (int i = 0; i < 9; i++) begin
            run_op(da[i], db[i], ds[i], $sformatf("dir%0d", i), (i == 0));
        end

        // Start and operand changes while busy are ignored
        @(negedge clk);
        dc0 = done_count;
        issue(32'd1000, 32'd13, 1'b0, "ignore_start", 1'b1);
        repeat (9) @(negedge clk);
        dividend  = 32'd5;
        divisor   = 32'd1;
        is_signed = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            dividend = $urandom;
            divisor  = $urandom;
            @(negedge clk);
        end
        repeat (70) @(negedge clk);
        check("ignore_start_single_done", 64'(done_count - dc0), 64'(1));

        // Flush with the counter at 20
        dc0 = done_count;
        issue(32'hDEAD_BEEF, 32'd77, 1'b0, "flushed", 1'b0);
        repeat (12) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_fall", 64'(busy), 64'(0));
        repeat (50) @(negedge clk);
        check("flush_no_done", 64'(done_count - dc0), 64'(0));
        check("flush_hi_kept", 64'(hi), 64'(last_hi));
        check("flush_lo_kept", 64'(lo), 64'(last_lo));
        run_op(32'd9, 32'd3, 1'b0, "after_flush", 1'b1);

        // Flush coincident with start in idle: nothing starts
        @(negedge clk);
        dc0 = done_count;
        start = 1'b1;
        flush = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("flush_start_no_done", 64'(done_count - dc0), 64'(0));

        // Asynchronous reset with the counter at 20
        dc0 = done_count;
        issue(32'hCAFE_F00D, 32'hFFFF_FF03, 1'b1, "reset_abort", 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rst_busy", 64'(busy), 64'(0));
        check("abort_rst_done", 64'(done), 64'(0));
        check("abort_rst_hi", 64'(hi), 64'(0));
        check("abort_rst_lo", 64'(lo), 64'(0));
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_rst_no_done", 64'(done_count - dc0), 64'(0));
        run_op(32'd9, 32'd3, 1'b0, "after_rst", 1'b1);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = '0;
                3: begin a = 32'($urandom_range(0, 1000)); b = a + 32'($urandom_range(1, 50)); end
                4: begin a = 32'h8000_0000 | 32'($urandom_range(0, 3)); b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
                default: b = ($urandom_range(0, 1) == 1) ? 32'h1 : 32'hFFFF_FFFF;
            endcase
            run_op(a, b, s, $sformatf("rnd%0d", i), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_hilo_divider.md
# seq_hilo_divider

Multi-cycle radix-2 restoring divider that executes MIPS DIV/DIVU and produces the values written into the HI/LO register pair. It sits between the CPU's decode outputs (rs/rt operands, div/divu strobes) and the HI/LO write path. It uses a start/busy/done handshake so the pipeline can stall on a fixed, known latency. Results follow MIPS convention: LO = quotient, HI = remainder.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin division; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  in  WIDTH  rs operand; sampled with start.
- divisor  in  WIDTH  rt operand; sampled with start.
- flush  in  1  synchronous abort (exception/eret); returns to IDLE with no done.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; hi/lo are valid and become the HI/LO write data.
- hi  out  WIDTH  remainder, registered and held until the next completion.
- lo  out  WIDTH  quotient, registered and held until the next completion.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE to CALC on start. Latch |dividend| and |divisor| (magnitudes only when is_signed), the quotient sign (sa^sb), the remainder sign (sa), and is_signed. Clear the partial remainder. Set the counter to WIDTH.
  - CALC performs one restoring step per cycle: shift {rem, quo} left 1, trial-subtract the divisor magnitude, set the quotient bit if the result is ≥ 0, and decrement the counter. Go to FIX when the counter reaches 1 on this step.
  - FIX applies the signs: lo = quotient sign ? -q : q; hi = remainder sign ? -r : r. Register hi/lo, pulse done, and return to IDLE.
- Unsigned mode never negates.
- Width rules:
  - The trial subtraction is WIDTH+1 bits wide.
  - abs(0x80000000) is taken as unsigned 0x80000000.
  - All negation is modulo 2^WIDTH.
- Divide by zero needs no special case; the outcome is the natural algorithmic result and must be exactly:
  - Unsigned: lo = 0xFFFFFFFF, hi = dividend.
  - Signed: lo = (dividend < 0) ? 0x00000001 : 0xFFFFFFFF, hi = dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- start while busy is ignored. Operand changes during CALC have no effect.
- flush in any state forces IDLE next cycle and suppresses done. hi/lo keep their previous values.
- flush and start in the same IDLE cycle: flush wins, and no operation starts.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, internal datapath 0.
- Edge E0 samples start in IDLE. busy rises after E0.
- CALC occupies edges E1..E32.
- FIX is the state entered at E32. Edge E33 registers hi/lo, and done is high from E33 to E34.
- Fixed latency: done is asserted 33 cycles after the start-sampling edge, independent of operands.
- busy falls at E33, coincident with done rising. A new start may be sampled at E34.
- No back-to-back overlap. Throughput is one division per 34 cycles.
- Asserting rst low mid-operation immediately clears all state. No done is issued for the aborted division.

## Structure
- Shared package `mdu_pkg`:
  - State encoding (IDLE, CALC, FIX).
  - WIDTH default.
  - Iteration count constant.
  - Divide-by-zero and overflow result constants, for bench reuse.
- One natural sub-module, `div_sign_cond`: combinational conditional negate/absolute value, instantiated for operand conditioning and for result fix-up.
- The HI/LO registers remain outside this block. The consumer ORs done into the HI/LO write enable.

## Test plan
- Unsigned 100 / 7 → done exactly 33 cycles after start; lo = 14, hi = 2; busy high for 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Signed 7 / −2 → lo = 0xFFFFFFFD, hi = 0x1.
- Divide by zero: unsigned 0x1234 / 0 → lo = 0xFFFFFFFF, hi = 0x1234. Signed 0xFFFFFFF0 / 0 → lo = 0x1, hi = 0xFFFFFFF0.
- Signed 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. Unsigned 0xFFFFFFFF / 1 → lo = 0xFFFFFFFF, hi = 0.
- Pulse start with new operands at cycle 10 of a running op, and change operands mid-CALC → ignored; the first result is unchanged and only one done pulse occurs.
- Abort mid-operation (counter = 20):
  - flush → busy falls the next cycle, no done, hi/lo keep their prior values.
  - Repeat with rst low → all outputs read 0.
  - In both cases, a subsequent 9 / 3 yields lo = 3, hi = 0.
